// File: rtl/watch_unit.sv
// Address watch unit: counts qualifying sniffed bus accesses against a programmable
// countdown, pulses nmi on expiry and reloads from the period register.
module watch_unit #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MIN_PERIOD     = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                wu_control,
  input  logic [DATA_WIDTH-1:0]     inDBB,
  input  logic [ADDR_BUS_WIDTH-1:0] bus_addr,
  input  logic                      bus_rw,
  input  logic                      bus_valid,
  output logic [DATA_WIDTH-1:0]     wDataWU,
  output logic                      nmi,
  output logic [1:0]                state
);

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_TRIP     = 2'd2;

  localparam logic [DATA_WIDTH-1:0] MIN_P = DATA_WIDTH'(MIN_PERIOD);
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);

  logic [ADDR_BUS_WIDTH-1:0] laddr_q, laddr_d;
  logic [ADDR_BUS_WIDTH-1:0] uaddr_q, uaddr_d;
  logic [DATA_WIDTH-1:0]     period_q, period_d;
  logic [DATA_WIDTH-1:0]     counter_q, counter_d;
  logic [1:0]                state_q, state_d;
  logic [3:0]                pulse_q, pulse_d;

  logic sniffOn, writeOn, readOn, rangeOn;
  logic [3:0] rise;
  logic loadLaddr, loadUaddr, loadPeriod, loadCount;
  logic addrMatch, hit, countHit;
  logic [DATA_WIDTH-1:0] newPeriod;
  logic unused_ctrl;

  assign sniffOn = wu_control[0];
  assign writeOn = wu_control[1];
  assign readOn  = wu_control[2];
  assign rangeOn = wu_control[3];
  assign unused_ctrl = ^wu_control[8:7];

  // Load pulses order: {n_count, n_period, n_uaddr, n_laddr}
  assign pulse_d    = {wu_control[9], wu_control[6], wu_control[5], wu_control[4]};
  assign rise       = pulse_d & ~pulse_q;
  assign loadLaddr  = rise[0];
  assign loadUaddr  = rise[1];
  assign loadPeriod = rise[2];
  assign loadCount  = rise[3];

  always_comb begin
    addrMatch = 1'b0;
    if (rangeOn) begin
      addrMatch = (laddr_q <= uaddr_q) && (bus_addr >= laddr_q) && (bus_addr <= uaddr_q);
    end else begin
      addrMatch = (bus_addr == laddr_q);
    end
  end

  assign hit = bus_valid & sniffOn & ((bus_rw & readOn) | (~bus_rw & writeOn)) & addrMatch;
  // Loads to the counter or period take precedence; a colliding hit is dropped.
  assign countHit  = hit && (state_q != ST_DISABLED) && !loadCount && !loadPeriod;
  assign newPeriod = (inDBB == '0) ? MIN_P : inDBB;

  always_comb begin
    laddr_d   = loadLaddr ? ADDR_BUS_WIDTH'(inDBB) : laddr_q;
    uaddr_d   = loadUaddr ? ADDR_BUS_WIDTH'(inDBB) : uaddr_q;
    period_d  = loadPeriod ? newPeriod : period_q;
    counter_d = counter_q;
    state_d   = ST_ARMED;

    if (loadCount) begin
      counter_d = inDBB;
    end else if (loadPeriod) begin
      counter_d = newPeriod;
    end else if (countHit) begin
      counter_d = (counter_q <= ONE) ? period_q : counter_q - ONE;
    end

    if (!sniffOn) begin
      state_d = ST_DISABLED;
    end else if (countHit && (counter_q <= ONE)) begin
      state_d = ST_TRIP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      laddr_q   <= '0;
      uaddr_q   <= '0;
      period_q  <= MIN_P;
      counter_q <= '0;
      state_q   <= ST_DISABLED;
      pulse_q   <= '0;
    end else begin
      laddr_q   <= laddr_d;
      uaddr_q   <= uaddr_d;
      period_q  <= period_d;
      counter_q <= counter_d;
      state_q   <= state_d;
      pulse_q   <= pulse_d;
    end
  end

  assign wDataWU = counter_q;
  assign nmi     = (state_q == ST_TRIP);
  assign state   = state_q;

endmodule

// File: tb/tb_watch_unit.sv
// Testbench for watch_unit: fixed vector table, hand-written reset sequence and
// randomized traffic compared against a behavioural model.
module tb_watch_unit;

  localparam logic [9:0] S   = 10'h001;
  localparam logic [9:0] WR  = 10'h002;
  localparam logic [9:0] RD  = 10'h004;
  localparam logic [9:0] RNG = 10'h008;
  localparam logic [9:0] LA  = 10'h010;
  localparam logic [9:0] UA  = 10'h020;
  localparam logic [9:0] PER = 10'h040;
  localparam logic [9:0] CNT = 10'h200;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  wu_control;
  logic [31:0] inDBB;
  logic [31:0] bus_addr;
  logic        bus_rw;
  logic        bus_valid;
  logic [31:0] wDataWU;
  logic        nmi;
  logic [1:0]  state;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model kept in plain spec terms
  logic [31:0] mLaddr, mUaddr, mPeriod, mCount;
  int          mState;
  logic [9:0]  mPrevCtrl;

  typedef struct {
    logic [9:0]  ctrl;
    logic [31:0] data;
    logic [31:0] addr;
    logic        rw;
    logic        valid;
    logic [31:0] expCount;
    logic        expNmi;
    logic [1:0]  expState;
  } vec_t;

  vec_t vecs[$];

  watch_unit #(.ADDR_BUS_WIDTH(32), .DATA_WIDTH(32), .MIN_PERIOD(15)) dut (
    .clk(clk), .reset(reset), .wu_control(wu_control), .inDBB(inDBB),
    .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_valid(bus_valid),
    .wDataWU(wDataWU), .nmi(nmi), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [9:0] c, logic [31:0] d, logic [31:0] a, logic rw,
                              logic v, logic [31:0] ec, logic en, logic [1:0] es);
    vec_t r;
    r.ctrl = c; r.data = d; r.addr = a; r.rw = rw; r.valid = v;
    r.expCount = ec; r.expNmi = en; r.expState = es;
    return r;
  endfunction

  task automatic modelReset();
    mLaddr = 0; mUaddr = 0; mPeriod = 15; mCount = 0; mState = 0; mPrevCtrl = 0;
  endtask

  task automatic modelClock(logic [9:0] c, logic [31:0] d, logic [31:0] a, logic rw, logic v);
    bit ldLa, ldUa, ldPer, ldCnt, inWindow, wanted, counts;
    logic [31:0] freshPeriod;
    ldLa  = c[4] && !mPrevCtrl[4];
    ldUa  = c[5] && !mPrevCtrl[5];
    ldPer = c[6] && !mPrevCtrl[6];
    ldCnt = c[9] && !mPrevCtrl[9];
    inWindow = c[3] ? (a >= mLaddr && a <= mUaddr) : (a == mLaddr);
    wanted = v && c[0] && (rw ? c[2] : c[1]) && inWindow;
    counts = wanted && (mState != 0) && !ldCnt && !ldPer;
    freshPeriod = (d == 0) ? 32'd15 : d;
    if (!c[0]) mState = 0;
    else if (counts && mCount <= 1) mState = 2;
    else mState = 1;
    if (ldCnt) mCount = d;
    else if (ldPer) mCount = freshPeriod;
    else if (counts) mCount = (mCount <= 1) ? mPeriod : mCount - 1;
    if (ldPer) mPeriod = freshPeriod;
    if (ldLa) mLaddr = d;
    if (ldUa) mUaddr = d;
    mPrevCtrl = c;
  endtask

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, clocks it, advances the model and samples #1 later.
  task automatic applyStimulus(logic [9:0] c, logic [31:0] d, logic [31:0] a, logic rw, logic v);
    wu_control = c; inDBB = d; bus_addr = a; bus_rw = rw; bus_valid = v;
    @(posedge clk);
    modelClock(c, d, a, rw, v);
    #1;
  endtask

  task automatic doReset();
    wu_control = 0; inDBB = 0; bus_addr = 0; bus_rw = 0; bus_valid = 0;
    reset = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_count", wDataWU, 32'd0);
    checkOutput("reset_nmi", {31'd0, nmi}, 32'd0);
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] c;
    logic [31:0] d, a;

    vecs.push_back(mk(S|WR,         0,      0,      0, 0,  0, 0, 1));
    vecs.push_back(mk(S|WR|LA,      'h1000, 0,      0, 0,  0, 0, 1));
    vecs.push_back(mk(S|WR|PER,     3,      0,      0, 0,  3, 0, 1));
    vecs.push_back(mk(S|WR,         0,      'h1000, 0, 1,  2, 0, 1));
    vecs.push_back(mk(S|WR,         0,      'h1000, 0, 1,  1, 0, 1));
    vecs.push_back(mk(S|WR,         0,      'h1000, 0, 1,  3, 1, 2));
    vecs.push_back(mk(S|WR,         0,      0,      0, 0,  3, 0, 1));
    vecs.push_back(mk(S|RD|RNG|LA,  'h100,  0,      0, 0,  3, 0, 1));
    vecs.push_back(mk(S|RD|RNG|UA,  'h1FF,  0,      0, 0,  3, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT, 10,     0,      0, 0, 10, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h0FF,  1, 1, 10, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h100,  1, 1,  9, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h1FF,  1, 1,  8, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h200,  1, 1,  8, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h150,  0, 1,  8, 0, 1));
    vecs.push_back(mk(S|RD|RNG|PER, 0,      0,      0, 0, 15, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT, 1,      0,      0, 0,  1, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h150,  1, 1, 15, 1, 2));
    vecs.push_back(mk(S|RD|RNG,     0,      0,      0, 0, 15, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT, 7,      'h150,  1, 1,  7, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT, 9,      'h150,  1, 1,  6, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT, 9,      'h150,  1, 1,  5, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT, 9,      'h150,  1, 1,  4, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      0,      0, 0,  4, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT, 5,      0,      0, 0,  5, 0, 1));
    vecs.push_back(mk(RD|RNG,       0,      'h150,  1, 1,  5, 0, 0));
    vecs.push_back(mk(RD|RNG,       0,      'h150,  1, 1,  5, 0, 0));
    vecs.push_back(mk(S|RD|RNG,     0,      'h150,  1, 1,  5, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h150,  1, 1,  4, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT, 1,      0,      0, 0,  1, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h150,  1, 1, 15, 1, 2));
    vecs.push_back(mk(S|RD|RNG|PER, 1,      'h150,  1, 1,  1, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h150,  1, 1,  1, 1, 2));
    vecs.push_back(mk(S|RD|RNG,     0,      'h150,  1, 1,  1, 1, 2));
    vecs.push_back(mk(S|RD|RNG,     0,      0,      0, 0,  1, 0, 1));
    vecs.push_back(mk(S|RD|RNG|CNT|PER, 0,  0,      0, 0,  0, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h150,  1, 1, 15, 1, 2));
    vecs.push_back(mk(S|RD|RNG,     0,      0,      0, 0, 15, 0, 1));
    vecs.push_back(mk(S|WR|LA,      'h2000, 'h100,  0, 1, 14, 0, 1));
    vecs.push_back(mk(S|WR,         0,      'h100,  0, 1, 14, 0, 1));
    vecs.push_back(mk(S|WR,         0,      'h2000, 0, 1, 13, 0, 1));
    vecs.push_back(mk(S|RD|RNG|LA,  'h300,  0,      0, 0, 13, 0, 1));
    vecs.push_back(mk(S|RD|RNG,     0,      'h300,  1, 1, 13, 0, 1));

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].data, vecs[i].addr, vecs[i].rw, vecs[i].valid);
      checkOutput($sformatf("vec%0d_count", i), wDataWU, vecs[i].expCount);
      checkOutput($sformatf("vec%0d_nmi", i), {31'd0, nmi}, {31'd0, vecs[i].expNmi});
      checkOutput($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].expState});
    end

    // Asynchronous reset in the middle of a count, then expiry from a zero counter
    applyStimulus(S|WR|CNT, 2, 0, 0, 0);
    checkOutput("pre_reset_count", wDataWU, 32'd2);
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset_count", wDataWU, 32'd0);
    checkOutput("async_reset_state", {30'd0, state}, 32'd0);
    checkOutput("async_reset_nmi", {31'd0, nmi}, 32'd0);
    #3 reset = 1'b1;
    applyStimulus(S|WR, 0, 0, 0, 0);
    checkOutput("rearm_state", {30'd0, state}, 32'd1);
    applyStimulus(S|WR, 0, 0, 0, 1);
    checkOutput("zero_expire_nmi", {31'd0, nmi}, 32'd1);
    checkOutput("zero_expire_count", wDataWU, 32'd15);

    // Randomized traffic against the reference model
    doReset();
    for (int n = 0; n < 1500; n++) begin
      c = 10'($urandom);
      c[0] = ($urandom_range(0, 9) != 0);
      c[4] = ($urandom_range(0, 5) == 0);
      c[5] = ($urandom_range(0, 5) == 0);
      c[6] = ($urandom_range(0, 7) == 0);
      c[9] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) d = 32'h40 + 32'($urandom_range(0, 32));
      else d = 32'($urandom_range(0, 6));
      a = 32'h40 + 32'($urandom_range(0, 32));
      applyStimulus(c, d, a, 1'($urandom), ($urandom_range(0, 9) < 7));
      checkOutput($sformatf("rand%0d_count", n), wDataWU, mCount);
      checkOutput($sformatf("rand%0d_nmi", n), {31'd0, nmi}, {31'd0, (mState == 2)});
      checkOutput($sformatf("rand%0d_state", n), {30'd0, state}, 32'(mState));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
